// File: rtl/key_expansion_seq_if.sv
// Round-key stream bundle between the AES-128 key schedule and the cipher datapath.
interface key_expansion_seq_if;
   logic         start_in;
   logic [127:0] key_in;
   logic         round_key_ready_in;
   logic [127:0] round_key_out;
   logic [3:0]   round_idx_out;
   logic         round_key_valid_out;
   logic         busy_out;
   logic         done_out;

   // Controller / cipher side: issues keys and accepts round keys
   modport master (
      output start_in, key_in, round_key_ready_in,
      input  round_key_out, round_idx_out, round_key_valid_out, busy_out, done_out
   );

   // Key schedule side
   modport slave (
      input  start_in, key_in, round_key_ready_in,
      output round_key_out, round_idx_out, round_key_valid_out, busy_out, done_out
   );
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule: emits round keys 0..10, one 32-bit word computed per cycle.
module key_expansion_seq #(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic                clk,
   input  logic                rst,
   key_expansion_seq_if.slave  bus
);
   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned CNT_W  = 2;

   typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_CALC} state_e;

   state_e             state_q, state_d;
   logic [WORD_W-1:0]  w_q [4];
   logic [WORD_W-1:0]  w_d [4];
   logic [IDX_W-1:0]   round_q, round_d;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               hs_c;
   logic               last_round_c;
   logic [WORD_W-1:0]  rot_c;
   logic [WORD_W-1:0]  sub_rot_c;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // AES S-box: multiplicative inverse (x^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Round constants for rounds 1..10
   function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign hs_c         = valid_q & bus.round_key_ready_in;
   assign last_round_c = (round_q == IDX_W'(NUM_ROUNDS));
   assign rot_c        = {w_q[3][23:0], w_q[3][31:24]};
   assign sub_rot_c    = {sbox(rot_c[31:24]), sbox(rot_c[23:16]),
                          sbox(rot_c[15:8]),  sbox(rot_c[7:0])};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) w_q[i] <= '0;
         round_q    <= '0;
         word_cnt_q <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
         round_q    <= round_d;
         word_cnt_q <= word_cnt_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start_in) state_d = ST_EMIT;
         ST_EMIT: if (hs_c) state_d = last_round_c ? ST_IDLE : ST_CALC;
         ST_CALC: if (word_cnt_q == CNT_W'(3)) state_d = ST_EMIT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Word update, round bookkeeping and registered status outputs
   always_comb begin
      w_d        = w_q;
      round_d    = round_q;
      word_cnt_d = word_cnt_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start_in) begin
               w_d[0]  = bus.key_in[127:96];
               w_d[1]  = bus.key_in[95:64];
               w_d[2]  = bus.key_in[63:32];
               w_d[3]  = bus.key_in[31:0];
               round_d = '0;
            end
         end
         ST_EMIT: begin
            if (hs_c) begin
               if (last_round_c) begin
                  done_d = 1'b1;
               end else begin
                  round_d    = round_q + IDX_W'(1);
                  word_cnt_d = '0;
               end
            end
         end
         ST_CALC: begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (word_cnt_q == '0)
               w_d[0] = w_q[0] ^ sub_rot_c ^ {rcon(round_q), 24'h000000};
            else
               w_d[word_cnt_q] = w_q[word_cnt_q] ^ w_q[word_cnt_q - CNT_W'(1)];
         end
         default: ;
      endcase
      valid_d = (state_d == ST_EMIT);
      busy_d  = (state_d != ST_IDLE);
   end

   assign bus.round_key_out       = {w_q[0], w_q[1], w_q[2], w_q[3]};
   assign bus.round_idx_out       = round_q;
   assign bus.round_key_valid_out = valid_q;
   assign bus.busy_out            = busy_q;
   assign bus.done_out            = done_q;
endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq against a whole-schedule AES-128 reference model.
module tb_key_expansion_seq;
   typedef struct packed {
      logic [3:0]   idx;
      logic [127:0] key;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   key_expansion_seq_if bus();
   key_expansion_seq #(.NUM_ROUNDS(10)) dut (.clk(clk), .rst(rst), .bus(bus));

   int           errors = 0;
   int           checks = 0;
   exp_t         sb_q[$];
   logic [127:0] got_key [11];
   int           ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
   bit           expect_done = 1'b0;
   int           hs_count = 0;
   int           done_seen = 0;
   logic [7:0]   sbox_tab [256];
   logic [7:0]   rcon_tab [11];

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Polynomial product then reduction by 0x11b
   function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_tables();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox_tab[x] = s;
      end
      rcon_tab[0] = 8'h00;
      rcon_tab[1] = 8'h01;
      for (int i = 2; i < 11; i++) rcon_tab[i] = tb_gmul(rcon_tab[i-1], 8'h02);
   endtask

   // Textbook 44-word expansion; returns round key r
   function automatic logic [127:0] model_key(input logic [127:0] k, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                ^ {rcon_tab[i/4], 24'h000000};
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // Downstream ready pattern
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       bus.round_key_ready_in = 1'b0;
         1:       bus.round_key_ready_in = 1'b1;
         default: bus.round_key_ready_in = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: compare presented round keys against the scoreboard head, pop on handshake
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (expect_done) begin
            check("done_pulse", 128'(bus.done_out), 128'd1);
            expect_done = 1'b0;
         end else if (bus.done_out !== 1'b0) begin
            check("spurious_done", 128'(bus.done_out), 128'd0);
         end
         if (bus.done_out === 1'b1) done_seen++;
         if (bus.round_key_valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("valid_with_empty_scoreboard", 128'(bus.round_key_valid_out), 128'd0);
            end else begin
               check("round_idx", 128'(bus.round_idx_out), 128'(sb_q[0].idx));
               check("round_key", bus.round_key_out, sb_q[0].key);
               check("busy_in_emit", 128'(bus.busy_out), 128'd1);
               if (bus.round_key_ready_in === 1'b1) begin
                  if (bus.round_idx_out <= 4'd10) got_key[bus.round_idx_out] = bus.round_key_out;
                  if (sb_q[0].idx == 4'd10) expect_done = 1'b1;
                  hs_count++;
                  void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   // Issue start (caller is 1 time unit after a rising edge) and queue all 11 expected keys
   task automatic start_run(input logic [127:0] k);
      bus.start_in = 1'b1;
      bus.key_in   = k;
      for (int r = 0; r <= 10; r++) sb_q.push_back('{idx: 4'(r), key: model_key(k, r)});
      @(posedge clk); #1;
      bus.start_in = 1'b0;
      bus.key_in   = {$urandom, $urandom, $urandom, $urandom};
      check("first_valid_latency", 128'(bus.round_key_valid_out), 128'd1);
   endtask

   task automatic wait_done(input int max, output int cyc);
      cyc = 0;
      while (bus.done_out !== 1'b1 && cyc < max) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (bus.done_out !== 1'b1) check("done_timeout", 128'(bus.done_out), 128'd1);
   endtask

   task automatic wait_cond_idx(input logic [3:0] idx, input logic valid, input int max);
      int n;
      n = 0;
      while (!(bus.round_idx_out === idx && bus.round_key_valid_out === valid) && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= max) check("wait_round_timeout", 128'(bus.round_idx_out), 128'(idx));
   endtask

   task automatic clear_got();
      for (int i = 0; i < 11; i++) got_key[i] = 'x;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int hs0;
      logic [127:0] k;
      rst          = 1'b1;
      bus.start_in = 1'b0;
      bus.key_in   = '0;
      build_tables();
      #12;
      check("reset_valid", 128'(bus.round_key_valid_out), 128'd0);
      check("reset_busy",  128'(bus.busy_out), 128'd0);
      check("reset_done",  128'(bus.done_out), 128'd0);
      check("reset_key",   bus.round_key_out, 128'd0);
      check("reset_idx",   128'(bus.round_idx_out), 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // FIPS-197 key, ready high: exact timing and known answers
      ready_mode = 1;
      clear_got();
      hs0 = hs_count;
      start_run(FIPS_KEY);
      wait_done(200, cyc);
      check("start_to_done_cycles", 128'(cyc), 128'd51);
      check("busy_after_done", 128'(bus.busy_out), 128'd0);
      repeat (3) @(posedge clk);
      #1;
      check("fips_idx0", got_key[0], FIPS_KEY);
      check("fips_idx1", got_key[1], FIPS_R1);
      check("fips_idx10", got_key[10], FIPS_R10);
      check("fips_handshakes", 128'(hs_count - hs0), 128'd11);
      check("single_done_pulse", 128'(done_seen), 128'd1);

      // Same key with random back-pressure
      ready_mode = 2;
      clear_got();
      start_run(FIPS_KEY);
      wait_done(2000, cyc);
      check("fips_rand_idx1", got_key[1], FIPS_R1);
      check("fips_rand_idx10", got_key[10], FIPS_R10);
      @(posedge clk); #1;

      // All-zero key
      clear_got();
      start_run(128'd0);
      wait_done(2000, cyc);
      check("zero_idx1", got_key[1], ZERO_R1);
      check("zero_idx10", got_key[10], ZERO_R10);
      @(posedge clk); #1;

      // Random keys with random back-pressure
      for (int t = 0; t < 6; t++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         start_run(k);
         wait_done(2000, cyc);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      @(posedge clk); #1;

      // Start pulsed during CALC of round 4 is ignored
      ready_mode = 1;
      start_run(FIPS_KEY);
      wait_cond_idx(4'd4, 1'b0, 100);
      bus.start_in = 1'b1;
      bus.key_in   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      bus.start_in = 1'b0;
      wait_done(200, cyc);
      check("ignored_start_done_cycles", 128'(cyc), 128'd34);
      @(posedge clk); #1;

      // Reset while holding round 6 in EMIT
      k = {$urandom, $urandom, $urandom, $urandom};
      start_run(k);
      wait_cond_idx(4'd6, 1'b0, 100);
      ready_mode = 0;
      wait_cond_idx(4'd6, 1'b1, 20);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      sb_q.delete();
      expect_done = 1'b0;
      #1;
      check("midrun_reset_valid", 128'(bus.round_key_valid_out), 128'd0);
      check("midrun_reset_busy",  128'(bus.busy_out), 128'd0);
      check("midrun_reset_key",   bus.round_key_out, 128'd0);
      check("midrun_reset_idx",   128'(bus.round_idx_out), 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ready_mode = 1;
      @(posedge clk); #1;
      clear_got();
      k = {$urandom, $urandom, $urandom, $urandom};
      start_run(k);
      check("post_reset_idx0_key", bus.round_key_out, k);
      wait_done(200, cyc);

      // Back-to-back: start in the done-pulse cycle
      k = {$urandom, $urandom, $urandom, $urandom};
      start_run(k);
      check("b2b_idx0_key", bus.round_key_out, k);
      wait_done(200, cyc);
      check("b2b_start_to_done_cycles", 128'(cyc), 128'd51);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
